// File: rtl/stack_sequencer.sv
// Stack pointer owner: sequences PUSH/POP/CALL/RET into byte-wide memory accesses.
// Optional STACK_GUARD_EN macro turns overflow/underflow into a faulting no-op.
module stack_sequencer #(
  parameter int              ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] SP_INIT  = 'h3E,
  parameter logic [ADDR_W-1:0] SP_LIMIT = 'h00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic [15:0]       push_data,
  output logic              op_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       pop_data,
  output logic              done,
  output logic              jump_valid,
  output logic [ADDR_W-1:0] stack_ptr,
  output logic              empty,
  output logic              full,
  output logic              fault
);

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] sp;
  logic              jmp_q;
  logic [15:0]       data_q;
  logic [7:0]        lo_q;
  logic [15:0]       pop_q;
  logic              fault_q;
  logic              accept;
  logic              guard_hit;

  assign accept = op_valid && (state == IDLE);

`ifdef STACK_GUARD_EN
  // op_code[0] distinguishes pop-type (underflow check) from push-type (overflow check)
  assign guard_hit = op_code[0] ? (sp == SP_INIT) : (sp == SP_LIMIT);
`else
  assign guard_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      sp      <= SP_INIT;
      jmp_q   <= 1'b0;
      data_q  <= '0;
      lo_q    <= '0;
      pop_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        jmp_q   <= op_code[1];
        data_q  <= push_data;
        fault_q <= guard_hit;
      end
      case (state)
        WR_HI:   sp <= sp - ADDR_W'(2);
        RD_HI:   lo_q <= mem_rdata;
        RD_CAP: begin
          pop_q <= {mem_rdata, lo_q};
          sp    <= sp + ADDR_W'(2);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          if (guard_hit)       state_nxt = DONE;
          else if (op_code[0]) state_nxt = RD_LO;
          else                 state_nxt = WR_LO;
        end
      end
      WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = sp - ADDR_W'(2);
        mem_wdata = data_q[7:0];
        state_nxt = WR_HI;
      end
      WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = sp - ADDR_W'(1);
        mem_wdata = data_q[15:8];
        state_nxt = DONE;
      end
      RD_LO: begin
        mem_re    = 1'b1;
        mem_addr  = sp;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        mem_re    = 1'b1;
        mem_addr  = sp + ADDR_W'(1);
        state_nxt = RD_CAP;
      end
      RD_CAP:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign op_ready   = (state == IDLE);
  assign done       = (state == DONE);
  assign jump_valid = done && jmp_q && !fault_q;
  assign pop_data   = pop_q;
  assign stack_ptr  = sp;
  assign empty      = (sp == SP_INIT);
  assign full       = (sp == SP_LIMIT);

`ifdef STACK_GUARD_EN
  assign fault = done && fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Randomized bench for stack_sequencer against a stack-level reference model.
module tb_stack_sequencer;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [7:0] INIT  = 8'h3E;
  localparam logic [7:0] LIMIT = 8'h00;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'd0;
  logic [15:0] push_data = 16'd0;
  logic        op_ready;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'd0;
  logic [15:0] pop_data;
  logic        done;
  logic        jump_valid;
  logic [7:0]  stack_ptr;
  logic        empty;
  logic        full;
  logic        fault;

  stack_sequencer dut (
    .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op_code(op_code),
    .push_data(push_data), .op_ready(op_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .pop_data(pop_data), .done(done), .jump_valid(jump_valid), .stack_ptr(stack_ptr),
    .empty(empty), .full(full), .fault(fault)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, one-cycle read latency
  bit [7:0] dmem [256];
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= dmem[mem_addr];
  end

  // Reference model state: what the stack should look like
  bit [7:0]  mm [256];
  bit [7:0]  m_sp;
  bit [15:0] m_pop;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tup(input bit we, input bit re, input bit [7:0] a, input bit [7:0] d);
    return {14'd0, we, re, (we || re) ? a : 8'h00, we ? d : 8'h00};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sp", stack_ptr, INIT);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", op_ready, 1);
    chk("rst_strobes", {mem_we, mem_re, done, jump_valid, fault}, 0);
    chk("rst_bus", {mem_addr, mem_wdata}, 0);
    chk("rst_pop", pop_data, 0);
    reset_n = 1'b1;
    m_sp  = INIT;
    m_pop = 16'd0;
  endtask

  task automatic do_op(input logic [1:0] code, input logic [15:0] data);
    logic [31:0] e [3];
    int          n_exp;
    bit          flt;
    bit          got;
    int          cyc;
    flt = GUARD && (code[0] ? (m_sp == INIT) : (m_sp == LIMIT));
    e[0] = 0; e[1] = 0; e[2] = 0;
    if (flt) begin
      n_exp = 0;
    end else if (!code[0]) begin
      n_exp = 2;
      e[0] = tup(1, 0, m_sp - 8'd2, data[7:0]);
      e[1] = tup(1, 0, m_sp - 8'd1, data[15:8]);
      mm[m_sp - 8'd2] = data[7:0];
      mm[m_sp - 8'd1] = data[15:8];
      m_sp = m_sp - 8'd2;
    end else begin
      n_exp = 3;
      e[0] = tup(0, 1, m_sp, 8'd0);
      e[1] = tup(0, 1, m_sp + 8'd1, 8'd0);
      m_pop = {mm[m_sp + 8'd1], mm[m_sp]};
      m_sp = m_sp + 8'd2;
    end

    chk("ready_before", op_ready, 1);
    op_valid  = 1'b1;
    op_code   = code;
    push_data = data;
    @(posedge clk);
    #1 op_valid = 1'b0;
    push_data = $urandom;
    got = 0;
    cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        cyc = c;
        break;
      end
      chk("access", tup(mem_we, mem_re, mem_addr, mem_wdata), (c <= n_exp) ? e[c-1] : 32'hDEAD);
    end
    if (!got) begin
      chk("timeout", 0, 1);
    end else begin
      chk("latency", cyc, n_exp + 1);
      chk("jump", jump_valid, code[1] && !flt);
      chk("fault", fault, flt);
      chk("pop_data", pop_data, m_pop);
      chk("sp", stack_ptr, m_sp);
      chk("flags", {empty, full}, {m_sp == INIT, m_sp == LIMIT});
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("ready_after", op_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_sp = INIT;
    m_pop = 0;
    do_reset();

    do_op(2'd0, 16'hBEEF);
    do_op(2'd1, 16'h0000);
    do_op(2'd2, 16'h0123);
    do_op(2'd3, 16'h0000);

    for (int i = 0; i < 80; i++)
      do_op(2'($urandom_range(0, 3)), 16'($urandom));

    // fill the stack, then one push beyond full
    do_reset();
    for (int i = 0; i < 31; i++) do_op(2'd0, 16'($urandom));
    chk("full_sp", stack_ptr, 8'h00);
    chk("full_flag", full, 1);
    do_op(2'd0, 16'hA55A);
    do_op(2'd2, 16'h1234);

    // pop on empty
    do_reset();
    do_op(2'd1, 16'h0000);
    do_op(2'd3, 16'h0000);

    // reset during WR_HI of a push at SP=3C
    do_reset();
    do_op(2'd0, 16'h1111);
    @(negedge clk);
    op_valid  = 1'b1;
    op_code   = 2'd0;
    push_data = 16'hC0DE;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_wrhi", {mem_we, mem_addr}, {1'b1, 8'h3B});
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_we", mem_we, 0);
    chk("mid_sp", stack_ptr, INIT);
    chk("mid_done", done, 0);
    reset_n = 1'b1;
    mm[8'h3A] = 8'hDE;
    mm[8'h3B] = 8'hC0;
    m_sp  = INIT;
    m_pop = 0;
    @(negedge clk);
    chk("mid_done2", done, 0);
    chk("mid_ready", op_ready, 1);
    do_op(2'd0, 16'h7E57);
    do_op(2'd1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
